// File: rtl/riscv_pkg.sv
// Shared RV32I ALU decode definitions: opcodes, funct fields, ALU operations
// and the width-independent decoded-instruction record.
package riscv_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_t;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        alu_op_t     alu_op;
        logic        use_imm;
        logic [11:0] imm;
    } decode_t;

    // alt selects SUB for funct3=000 and SRA for funct3=101; ignored otherwise.
    function automatic alu_op_t f3_to_op(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/riscv_alu.sv
// Combinational integer ALU; shifts use the low log2(XLEN) bits of b_i.
module riscv_alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_t         alu_op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] y_o
);
    localparam int SH = $clog2(XLEN);

    logic [SH-1:0] shamt;
    assign shamt = b_i[SH-1:0];

    always_comb begin
        y_o = '0;
        case (alu_op_i)
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_SLL:  y_o = a_i << shamt;
            ALU_SLT:  y_o[0] = $signed(a_i) < $signed(b_i);
            ALU_SLTU: y_o[0] = a_i < b_i;
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_SRL:  y_o = a_i >> shamt;
            ALU_SRA:  y_o = $signed(a_i) >>> shamt;
            ALU_OR:   y_o = a_i | b_i;
            ALU_AND:  y_o = a_i & b_i;
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/riscv_pipe_core.sv
// Three-stage (fetch / execute / writeback) RV32I integer-ALU core with
// WB-to-EX forwarding, a retirement trace and a sticky illegal-instruction halt.
module riscv_pipe_core
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic            retire_valid,
    output logic [4:0]      retire_rd,
    output logic [XLEN-1:0] retire_data,
    output logic            zero,
    output logic            illegal
);
    localparam int          SH       = $clog2(XLEN);
    localparam int          RW       = $clog2(NREGS);
    localparam logic [5:0]  NREGS_W  = 6'(NREGS);
    localparam logic [11:0] SRAI_IMM = 12'h400;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            ex_valid_q;
    logic [31:0]     ex_instr_q;
    logic            wb_valid_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic            zero_q;
    logic            illegal_q, halt_d;
    logic [XLEN-1:0] rf_q [NREGS];

    decode_t         dec;
    logic            dec_bad, sr_alt;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] rs1_val, rs2_val, op_b, alu_y;
    logic            ex_bad, ex_retire, fetch_fire;

    function automatic logic reg_bad(input logic [4:0] idx);
        return {1'b0, idx} >= NREGS_W;
    endfunction

    assign f3 = ex_instr_q[14:12];
    assign f7 = ex_instr_q[31:25];

    always_comb begin
        dec         = '0;
        dec_bad     = 1'b0;
        sr_alt      = 1'b0;
        dec.rs1     = ex_instr_q[19:15];
        dec.rs2     = ex_instr_q[24:20];
        dec.rd      = ex_instr_q[11:7];
        dec.imm     = ex_instr_q[31:20];
        case (ex_instr_q[6:0])
            OP_R: begin
                dec.alu_op = f3_to_op(f3, f7 == F7_ALT);
                if (f7 == F7_ALT) dec_bad = (f3 != F3_ADD) && (f3 != F3_SR);
                else if (f7 != F7_BASE) dec_bad = 1'b1;
                if (reg_bad(dec.rs2)) dec_bad = 1'b1;
            end
            OP_IMM: begin
                dec.use_imm = 1'b1;
                sr_alt      = dec.imm[11:SH] == SRAI_IMM[11:SH];
                dec.alu_op  = f3_to_op(f3, (f3 == F3_SR) && sr_alt);
                // Shift immediates above the shamt field must be zero (SRAI marker excepted).
                if ((f3 == F3_SLL || f3 == F3_SR) && dec.imm[11:SH] != '0
                    && !(f3 == F3_SR && sr_alt))
                    dec_bad = 1'b1;
            end
            default: dec_bad = 1'b1;
        endcase
        if (reg_bad(dec.rs1) || reg_bad(dec.rd)) dec_bad = 1'b1;
    end

    // x0 reads as zero; otherwise the instruction in WB takes priority over the array.
    always_comb begin
        rs1_val = rf_q[dec.rs1[RW-1:0]];
        rs2_val = rf_q[dec.rs2[RW-1:0]];
        if (wb_valid_q && wb_rd_q == dec.rs1) rs1_val = wb_data_q;
        if (wb_valid_q && wb_rd_q == dec.rs2) rs2_val = wb_data_q;
        if (dec.rs1 == '0) rs1_val = '0;
        if (dec.rs2 == '0) rs2_val = '0;
    end

    assign op_b = dec.use_imm ? {{(XLEN-12){dec.imm[11]}}, dec.imm} : rs2_val;

    riscv_alu #(.XLEN(XLEN)) u_alu (
        .alu_op_i (dec.alu_op),
        .a_i      (rs1_val),
        .b_i      (op_b),
        .y_o      (alu_y)
    );

    assign ex_bad     = ex_valid_q & dec_bad;
    assign ex_retire  = ex_valid_q & ~dec_bad;
    assign halt_d     = illegal_q | ex_bad;
    assign fetch_fire = imem_req & imem_valid & ~ex_bad;
    assign pc_d       = fetch_fire ? pc_q + XLEN'(4) : pc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= PC_RESET;
            ex_valid_q <= 1'b0;
            ex_instr_q <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            zero_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            illegal_q  <= halt_d;
            ex_valid_q <= fetch_fire;
            if (fetch_fire) ex_instr_q <= imem_rdata;
            wb_valid_q <= ex_retire;
            if (ex_retire) begin
                wb_rd_q   <= dec.rd;
                wb_data_q <= alu_y;
                zero_q    <= alu_y == '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (wb_valid_q && wb_rd_q != '0) begin
            rf_q[wb_rd_q[RW-1:0]] <= wb_data_q;
        end
    end

    // Reset gates the combinational outputs so nothing is fetched or retired in a reset cycle.
    assign imem_req     = ~reset & ~illegal_q;
    assign imem_addr    = pc_q;
    assign retire_valid = wb_valid_q & ~reset;
    assign retire_rd    = wb_rd_q;
    assign retire_data  = wb_data_q;
    assign zero         = zero_q;
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_riscv_pipe_core.sv
// Randomised bench for riscv_pipe_core: an instruction-level reference model
// predicts every retirement, its cycle, the zero flag and the halt behaviour.
module tb_riscv_pipe_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_valid;
    logic [31:0] imem_addr, imem_rdata;
    logic        retire_valid, zero, illegal;
    logic [4:0]  retire_rd;
    logic [31:0] retire_data;

    logic        e_req, e_rv, e_zero, e_illegal;
    logic [31:0] e_addr, e_rdata, e_data;
    logic [4:0]  e_rd;

    always #5 clk = ~clk;

    riscv_pipe_core #(.XLEN(32), .NREGS(32), .PC_RESET(32'h0)) u_dut (
        .clock(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .retire_valid(retire_valid),
        .retire_rd(retire_rd), .retire_data(retire_data), .zero(zero), .illegal(illegal)
    );

    riscv_pipe_core #(.XLEN(32), .NREGS(16), .PC_RESET(32'h0)) u_dut_e (
        .clock(clk), .reset(reset), .imem_req(e_req), .imem_addr(e_addr),
        .imem_valid(1'b1), .imem_rdata(e_rdata), .retire_valid(e_rv),
        .retire_rd(e_rd), .retire_data(e_data), .zero(e_zero), .illegal(e_illegal)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {imm, 5'(rs1), f3, 5'(rd), 7'b0010011};
    endfunction

    // RV32E instance: x15 is legal, then a write to x17 must halt it.
    assign e_rdata = (e_addr == 32'd0) ? enc_i(12'd9, 0, 3'd0, 15) : enc_r(7'h00, 0, 0, 3'd0, 17);

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mreg [32];
    logic [31:0] prog [256];
    logic [31:0] m_pc;
    bit          m_halt, m_zero, halted_now, exp_rv;
    int          halt_cyc, cyc = 0;
    int          lat = 0, wait_cnt = 0;
    bit          rand_lat = 0, have_wait = 0;
    logic [31:0] wait_addr;
    exp_t        e;
    bit          ok;
    logic [4:0]  m_rd;
    logic [31:0] m_v;

    logic [4:0]  ret_rd[$];
    logic [31:0] ret_data[$];
    bit          ret_zero[$];
    int          ret_cyc[$];
    int          e_cnt = 0;
    logic [4:0]  e_last_rd;
    logic [31:0] e_last_data;

    // Executes one instruction architecturally; returns legality, rd and result.
    function automatic void iss(input logic [31:0] w, output bit legal,
                                output logic [4:0] rd, output logic [31:0] v);
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [4:0]  sh;
        bit          alt;
        op = w[6:0]; f7 = w[31:25]; f3 = w[14:12];
        rd = w[11:7]; a = mreg[w[19:15]];
        legal = 1; v = 0; alt = 0; b = 0;
        if (op == 7'h33) begin
            b = mreg[w[24:20]];
            alt = (f7 == 7'h20);
            legal = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
        end else if (op == 7'h13) begin
            b = {{20{w[31]}}, w[31:20]};
            alt = (f3 == 3'd5) && (f7 == 7'h20);
            if (f3 == 3'd1) legal = (f7 == 7'h00);
            if (f3 == 3'd5) legal = (f7 == 7'h00) || alt;
        end else begin
            legal = 0;
        end
        sh = b[4:0];
        case (f3)
            3'd0: v = (op == 7'h33 && alt) ? a - b : a + b;
            3'd1: v = a << sh;
            3'd2: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: v = (a < b) ? 32'd1 : 32'd0;
            3'd4: v = a ^ b;
            3'd5: begin
                v = a >> sh;
                if (alt && a[31]) v = v | ~(32'hFFFF_FFFF >> sh);
            end
            3'd6: v = a | b;
            default: v = a & b;
        endcase
        if (legal && rd != 5'd0) mreg[rd] = v;
    endfunction

    function automatic int pick_reg();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
        return int'($urandom_range(0, 5));
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [6:0]  f7;
        f3 = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) begin
            f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            return enc_r(f7, pick_reg(), pick_reg(), f3, pick_reg());
        end
        imm = 12'($urandom);
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return enc_i(imm, pick_reg(), f3, pick_reg());
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor + instruction-memory responder, both on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            chk("reset_retire", retire_valid, 0);
            chk("reset_req", imem_req, 0);
            q.delete();
            ret_rd.delete(); ret_data.delete(); ret_zero.delete(); ret_cyc.delete();
            for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
            m_pc = 32'd0; m_halt = 0; m_zero = 0; halt_cyc = 0;
            wait_cnt = 0; have_wait = 0;
            imem_valid = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
        end else begin
            exp_rv = (q.size() > 0) && (q[0].cyc == cyc);
            chk("retire_valid", retire_valid, exp_rv);
            if (exp_rv) begin
                e = q.pop_front();
                m_zero = (e.data == 32'd0);
                chk("retire_rd", retire_rd, e.rd);
                chk("retire_data", retire_data, e.data);
                $display("retire cyc=%0d rd=%0d data=%h zero=%0d", cyc, retire_rd, retire_data, zero);
            end
            if (retire_valid) begin
                ret_rd.push_back(retire_rd); ret_data.push_back(retire_data);
                ret_zero.push_back(zero); ret_cyc.push_back(cyc);
            end
            chk("zero", zero, m_zero);
            halted_now = m_halt && (cyc >= halt_cyc);
            chk("illegal", illegal, halted_now);
            chk("imem_req", imem_req, !halted_now);
            if (imem_req && have_wait) chk("addr_stable", imem_addr, wait_addr);
            if (imem_req) begin
                if (wait_cnt >= lat) begin
                    imem_valid = 1'b1;
                    imem_rdata = prog[imem_addr[9:2]];
                    chk("fetch_pc", imem_addr, m_pc);
                    if (!m_halt) begin
                        iss(imem_rdata, ok, m_rd, m_v);
                        m_pc = m_pc + 32'd4;
                        if (ok) q.push_back('{m_rd, m_v, cyc + 2});
                        else begin
                            m_halt = 1; halt_cyc = cyc + 2;
                        end
                    end
                    wait_cnt = 0; have_wait = 0;
                    if (rand_lat) lat = int'($urandom_range(0, 3));
                end else begin
                    imem_valid = 1'b0;
                    imem_rdata = $urandom;
                    wait_cnt++; have_wait = 1; wait_addr = imem_addr;
                end
            end else begin
                imem_valid = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
                have_wait = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) e_cnt = 0;
        else if (e_rv) begin
            e_cnt++; e_last_rd = e_rd; e_last_data = e_data;
        end
    end

    task automatic do_reset();
        @(posedge clk); #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        prog[0]  = enc_i(12'd5, 0, 3'd0, 1);              // ADDI x1,x0,5
        prog[1]  = enc_i(12'hFFD, 0, 3'd0, 2);            // ADDI x2,x0,-3
        prog[2]  = enc_r(7'h00, 2, 1, 3'd0, 3);           // ADD  x3,x1,x2
        prog[3]  = enc_r(7'h20, 1, 1, 3'd0, 4);           // SUB  x4,x1,x1
        prog[4]  = enc_i(12'd1, 0, 3'd0, 5);              // ADDI x5,x0,1
        prog[5]  = enc_i(12'h401, 2, 3'd5, 6);            // SRAI x6,x2,1
        prog[6]  = enc_i(12'h001, 2, 3'd5, 7);            // SRLI x7,x2,1
        prog[7]  = enc_r(7'h00, 1, 2, 3'd2, 8);           // SLT  x8,x2,x1
        prog[8]  = enc_r(7'h00, 1, 2, 3'd3, 9);           // SLTU x9,x2,x1
        prog[9]  = enc_i(12'd7, 0, 3'd0, 0);              // ADDI x0,x0,7
        prog[10] = enc_r(7'h00, 0, 0, 3'd0, 10);          // ADD  x10,x0,x0
        prog[11] = enc_i(12'd1, 0, 3'd0, 1);              // ADDI x1,x0,1
        prog[12] = 32'h0000_0073;                         // not an ALU opcode
        for (int i = 13; i < 256; i++) prog[i] = enc_i(12'd1, 0, 3'd0, 11);

        // Zero-wait memory: directed program up to the halt.
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_retire_rd", retire_rd, 0);
        chk("rst_retire_data", retire_data, 0);
        chk("rst_zero", zero, 0);
        chk("rst_illegal", illegal, 0);
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
        repeat (25) @(posedge clk);
        @(negedge clk); #1;
        chk("dir_count", ret_data.size(), 12);
        chk("dir_add_fwd", ret_data[2], 32'd2);
        chk("dir_b2b", ret_cyc[2] - ret_cyc[0], 2);
        chk("dir_sub_zero", {ret_data[3], 31'd0, ret_zero[3]}, {32'd0, 32'd1});
        chk("dir_zero_clr", ret_zero[4], 0);
        chk("dir_srai", ret_data[5], 32'hFFFF_FFFE);
        chk("dir_srli", ret_data[6], 32'h7FFF_FFFE);
        chk("dir_slt", ret_data[7], 32'd1);
        chk("dir_sltu", ret_data[8], 32'd0);
        chk("dir_x0_write", {27'd0, ret_rd[9], ret_data[9]}, {32'd0, 32'd7});
        chk("dir_x0_read", ret_data[10], 32'd0);
        chk("dir_halt", {illegal, imem_req}, 2'b10);

        // Three-cycle memory latency, then a mid-stream reset.
        lat = 3;
        do_reset();
        chk("post_halt_illegal", illegal, 0);
        repeat (22) @(posedge clk);
        @(negedge clk); #1;
        chk("lat_spacing0", ret_cyc[1] - ret_cyc[0], 4);
        chk("lat_spacing1", ret_cyc[2] - ret_cyc[1], 4);
        chk("lat_fwd", ret_data[2], 32'd2);

        // Random legal programs with random per-fetch latency.
        for (int i = 0; i < 256; i++) prog[i] = rand_insn();
        rand_lat = 1;
        do_reset();
        repeat (250) @(posedge clk);
        do_reset();
        repeat (250) @(posedge clk);
        @(negedge clk); #1;

        chk("rv32e_retires", e_cnt, 1);
        chk("rv32e_rd", e_last_rd, 15);
        chk("rv32e_data", e_last_data, 32'd9);
        chk("rv32e_halt", {e_illegal, e_req}, 2'b10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
